// File: rtl/mx2_sweep_pkg.sv
// Shared types and constants for the dual CC_MX2 sweep checker.
// Covers the vector encoding and the y field layout of the block under test.
package mx2_sweep_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int VEC_W = 6;
    localparam int Y_W   = 12;
    localparam logic [VEC_W-1:0] VEC_LAST = 6'd63;

    // Start bit of each y field group
    localparam int Y_MUX_LO   = 0;   // y[1:0]  mux outputs
    localparam int Y_PASS_LO  = 2;   // y[5:2]  d0/d1 pass-through pairs
    localparam int Y_SEL_LO   = 6;   // y[7:6]  select echo
    localparam int Y_CONST_LO = 8;   // y[11:8] fixed pattern

    localparam logic [3:0] Y_CONST = 4'b1010;

endpackage

// File: rtl/mx2_ref_model.sv
// Golden model of the dual CC_MX2 block.
// Maps a sweep vector {d0, d1, s} to the y value the block should produce.
module mx2_ref_model
    import mx2_sweep_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic [Y_W-1:0]   exp_y
);

    logic [1:0] d0;
    logic [1:0] d1;
    logic [1:0] s;

    assign d0 = vec[5:4];
    assign d1 = vec[3:2];
    assign s  = vec[1:0];

    // NOTE: default first so every path assigns exp_y and no latch is inferred.
    always_comb begin
        exp_y = '0;
        for (int i = 0; i < 2; i++) begin
            exp_y[Y_MUX_LO + i]      = s[i] ? d1[i] : d0[i];
            exp_y[Y_PASS_LO + 2*i]   = d0[i];
            exp_y[Y_PASS_LO + 2*i+1] = d1[i];
            exp_y[Y_SEL_LO + i]      = s[i];
        end
        exp_y[Y_CONST_LO +: 4] = Y_CONST;
    end

endmodule

// File: rtl/mx2_sweep_checker.sv
// Sweeps all 64 input combinations through the dual CC_MX2 block and checks y.
// Reports pass/fail, a saturating error count and the first failing vector.
module mx2_sweep_checker
    import mx2_sweep_pkg::*;
#(
    parameter int SETTLE = 1,
    parameter int ERR_W  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [1:0]       d0,
    output logic [1:0]       d1,
    output logic [1:0]       s,
    input  logic [Y_W-1:0]   y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [VEC_W-1:0] first_fail_vec,
    output logic [Y_W-1:0]   first_fail_y
);

    localparam logic [3:0]       SETTLE_L = 4'(SETTLE);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    state_t           state;
    logic [VEC_W-1:0] vec;
    logic [3:0]       hold;
    logic [Y_W-1:0]   exp_y;

    mx2_ref_model u_ref (
        .vec   (vec),
        .exp_y (exp_y)
    );

    // vec is a flop that is 0 in IDLE and parks at VEC_LAST in DONE,
    // so the stimulus outputs come straight from it.
    assign d0   = vec[5:4];
    assign d1   = vec[3:2];
    assign s    = vec[1:0];
    assign pass = done && (err_count == '0);

    // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            vec              <= '0;
            hold             <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            first_fail_y     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state            <= RUN;
                        vec              <= '0;
                        hold             <= '0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        err_count        <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                        first_fail_y     <= '0;
                    end
                end
                RUN: begin
                    if (hold != SETTLE_L) begin
                        hold <= hold + 4'd1;
                    end else begin
                        if (y != exp_y) begin
                            if (err_count != ERR_MAX)
                                err_count <= err_count + ERR_W'(1);
                            if (!first_fail_valid) begin
                                first_fail_valid <= 1'b1;
                                first_fail_vec   <= vec;
                                first_fail_y     <= y;
                            end
                        end
                        if (vec == VEC_LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            vec  <= vec + 6'd1;
                            hold <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mx2_sweep_checker.sv
// Directed bench for mx2_sweep_checker with a behavioural CC_MX2 block
// that can be faulted (y[3] stuck at 0, or y[6]/y[7] swapped).
module tb_mx2_sweep_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    int   fault_a = 0;
    int   fault_b = 0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   e0 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: SETTLE = 1, ERR_W = 7
    logic [1:0]  d0_a, d1_a, s_a;
    logic [11:0] y_a;
    logic        busy_a, done_a, pass_a, ffv_a;
    logic [6:0]  err_a;
    logic [5:0]  ffvec_a;
    logic [11:0] ffy_a;

    // Instance B: SETTLE = 0, ERR_W = 4
    logic [1:0]  d0_b, d1_b, s_b;
    logic [11:0] y_b;
    logic        busy_b, done_b, pass_b, ffv_b;
    logic [3:0]  err_b;
    logic [5:0]  ffvec_b;
    logic [11:0] ffy_b;

    // Standalone golden model, checked against hand-computed values
    logic [5:0]  ref_vec = '0;
    logic [11:0] ref_y;

    function automatic logic [11:0] blk_y(input logic [1:0] d0, input logic [1:0] d1,
                                          input logic [1:0] s, input int fault);
        logic [11:0] r;
        r[0]    = s[0] ? d1[0] : d0[0];
        r[1]    = s[1] ? d1[1] : d0[1];
        r[2]    = d0[0];
        r[3]    = d1[0];
        r[4]    = d0[1];
        r[5]    = d1[1];
        r[6]    = s[0];
        r[7]    = s[1];
        r[11:8] = 4'hA;
        if (fault == 1) r[3] = 1'b0;
        if (fault == 2) begin
            r[6] = s[1];
            r[7] = s[0];
        end
        return r;
    endfunction

    assign y_a = blk_y(d0_a, d1_a, s_a, fault_a);
    assign y_b = blk_y(d0_b, d1_b, s_b, fault_b);

    mx2_sweep_checker #(.SETTLE(1), .ERR_W(7)) dut_a (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start_a),
        .d0               (d0_a),
        .d1               (d1_a),
        .s                (s_a),
        .y                (y_a),
        .busy             (busy_a),
        .done             (done_a),
        .pass             (pass_a),
        .err_count        (err_a),
        .first_fail_valid (ffv_a),
        .first_fail_vec   (ffvec_a),
        .first_fail_y     (ffy_a)
    );

    mx2_sweep_checker #(.SETTLE(0), .ERR_W(4)) dut_b (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start_b),
        .d0               (d0_b),
        .d1               (d1_b),
        .s                (s_b),
        .y                (y_b),
        .busy             (busy_b),
        .done             (done_b),
        .pass             (pass_b),
        .err_count        (err_b),
        .first_fail_valid (ffv_b),
        .first_fail_vec   (ffvec_b),
        .first_fail_y     (ffy_b)
    );

    mx2_ref_model u_ref (
        .vec   (ref_vec),
        .exp_y (ref_y)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Start pulse sampled at edge E0; returns at the following negedge.
    task automatic pulse_start(input int inst);
        @(negedge clk);
        if (inst == 0) start_a = 1'b1;
        else           start_b = 1'b1;
        @(posedge clk);
        #1 e0 = cyc;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input int inst, output int lat);
        lat = -1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ((inst == 0) ? done_a : done_b) begin
                lat = cyc - e0;
                break;
            end
        end
    endtask

    task automatic wait_vec_a(input logic [5:0] v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ({d0_a, d1_a, s_a} == v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_zero_a(input string tag);
        check({tag, "_stim"},  {26'd0, d0_a, d1_a, s_a}, 32'd0);
        check({tag, "_flags"}, {29'd0, busy_a, done_a, pass_a}, 32'd0);
        check({tag, "_err"},   {25'd0, err_a}, 32'd0);
        check({tag, "_ff"},    {13'd0, ffv_a, ffvec_a, ffy_a}, 32'd0);
    endtask

    int lat;
    bit ok;

    initial begin
        #12;
        check_zero_a("rst");
        check("rst_b", {12'd0, busy_b, done_b, pass_b, err_b, ffv_b, ffvec_b, ffy_b}, 32'd0);

        // Golden model spot vectors
        ref_vec = 6'h00; #1 check("ref_00", ref_y, 12'hA00);
        ref_vec = 6'h3F; #1 check("ref_3f", ref_y, 12'hAFF);
        ref_vec = 6'h04; #1 check("ref_04", ref_y, 12'hA08);
        ref_vec = 6'h01; #1 check("ref_01", ref_y, 12'hA40);
        ref_vec = 6'h2D; #1 check("ref_2d", ref_y, 12'hA7B);

        @(negedge clk) rst_n = 1'b1;

        // Golden sweep with an ignored start at vec 10
        fault_a = 0;
        pulse_start(0);
        check("run_busy", busy_a, 1'b1);
        wait_vec_a(6'd10, ok);
        check("reach_v10", ok, 1'b1);
        start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        check("v10_stim_kept", {d0_a, d1_a, s_a}, 6'd10);
        wait_done(0, lat);
        check("gold_lat", lat, 128);
        check("gold_pass", {pass_a, busy_a}, 2'b10);
        check("gold_err", err_a, 7'd0);
        check("gold_ffv", ffv_a, 1'b0);
        check("done_stim", {d0_a, d1_a, s_a}, 6'h3F);

        // y[3] stuck at 0, started from DONE
        fault_a = 1;
        pulse_start(0);
        check("restart_done", {done_a, busy_a}, 2'b01);
        wait_done(0, lat);
        check("stuck_lat", lat, 128);
        check("stuck_err", err_a, 7'd32);
        check("stuck_ffvec", ffvec_a, 6'h04);
        check("stuck_ffy", ffy_a, 12'hA00);
        check("stuck_flags", {pass_a, ffv_a}, 2'b01);
        repeat (5) @(negedge clk);
        check("done_stable", {err_a, ffvec_a, ffy_a}, {7'd32, 6'h04, 12'hA00});

        // y[6]/y[7] swapped; restart must clear the previous capture
        fault_a = 2;
        pulse_start(0);
        check("clear_err", err_a, 7'd0);
        check("clear_ff", {ffv_a, ffvec_a, ffy_a}, 19'd0);
        wait_done(0, lat);
        check("swap_err", err_a, 7'd32);
        check("swap_ffvec", ffvec_a, 6'h01);
        check("swap_ffy", ffy_a, 12'hA80);

        // Reset mid-sweep at vec 20
        fault_a = 1;
        pulse_start(0);
        wait_vec_a(6'd20, ok);
        check("reach_v20", ok, 1'b1);
        check("v20_err", err_a, 7'd8);
        check("v20_ffvec", ffvec_a, 6'h04);
        rst_n = 1'b0;
        #1 check_zero_a("midrst");
        @(negedge clk) rst_n = 1'b1;
        fault_a = 0;
        pulse_start(0);
        wait_done(0, lat);
        check("post_rst_lat", lat, 128);
        check("post_rst_pass", pass_a, 1'b1);

        // Instance B: SETTLE = 0 timing, ERR_W = 4 saturation
        fault_b = 0;
        pulse_start(1);
        wait_done(1, lat);
        check("b_gold_lat", lat, 64);
        check("b_gold_pass", pass_b, 1'b1);
        fault_b = 1;
        pulse_start(1);
        wait_done(1, lat);
        check("b_sat_err", err_b, 4'd15);
        check("b_sat_pass", pass_b, 1'b0);
        check("b_sat_ffvec", ffvec_b, 6'h04);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
